// File: rtl/memory_player.sv
// Simon-style memory game: shows a growing prefix of the generator's 9-entry memory, then checks the player's repeat.
// Optional macro PLAYER_TIMEOUT_EN: an INPUT phase idle for T_TIMEOUT cycles ends the game as a loss.
module memory_player #(
    parameter int T_SHOW    = 100,
    parameter int T_GAP     = 25,
    parameter int T_TIMEOUT = 1000
) (
    input  logic       clock,
    input  logic       Resetn,
    input  logic       iniciar,
    input  logic       listo,
    input  logic [3:0] outMem,
    output logic [3:0] readAdd,
    input  logic [3:0] guess,
    input  logic       enter,
    output logic [3:0] mostrar,
    output logic       dispOn,
    output logic [3:0] ronda,
    output logic [5:0] aciertos,
    output logic       fin,
    output logic       gano,
    output logic       perdio
);

    if (T_SHOW < 1 || T_GAP < 1 || T_TIMEOUT < 1) begin : g_bad_params
        $error("memory_player: T_SHOW, T_GAP and T_TIMEOUT must all be at least 1");
    end

    localparam int SHOW_GAP_MAX = (T_SHOW > T_GAP) ? T_SHOW : T_GAP;
`ifdef PLAYER_TIMEOUT_EN
    localparam int CNT_MAX = (SHOW_GAP_MAX > T_TIMEOUT) ? SHOW_GAP_MAX : T_TIMEOUT;
`else
    localparam int CNT_MAX = SHOW_GAP_MAX;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(T_SHOW - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_GAP - 1);
`ifdef PLAYER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(T_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SHOW,
        GAP,
        INPUT,
        WIN,
        LOSE
    } state_t;

    state_t           state, state_n;
    logic [3:0]       idx, idx_n;
    logic [3:0]       ronda_n;
    logic [5:0]       aciertos_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             iniciar_prev, enter_prev;
    logic             iniciar_edge, enter_edge;

    assign iniciar_edge = iniciar & ~iniciar_prev;
    assign enter_edge   = enter & ~enter_prev;
    // idx is itself a register, so the address to the generator is registered too
    assign readAdd      = idx;

    always_ff @(posedge clock) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        ronda_n    = ronda;
        aciertos_n = aciertos;
        cnt_n      = '0;
        case (state)
            IDLE, WIN, LOSE: begin
                if (iniciar_edge) begin
                    ronda_n    = 4'd1;
                    idx_n      = 4'd0;
                    aciertos_n = 6'd0;
                    state_n    = listo ? SHOW : WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (listo) begin
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if ((idx + 4'd1) == ronda) begin
                        idx_n   = 4'd0;
                        state_n = INPUT;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = SHOW;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            INPUT: begin
`ifdef PLAYER_TIMEOUT_EN
                cnt_n = cnt + 1'b1;
`endif
                if (enter_edge) begin
                    if (guess == outMem) begin
                        aciertos_n = aciertos + 6'd1;
                        cnt_n      = '0;
                        if ((idx + 4'd1) == ronda) begin
                            idx_n = 4'd0;
                            if (ronda == 4'd9) begin
                                state_n = WIN;
                            end else begin
                                ronda_n = ronda + 4'd1;
                                state_n = SHOW;
                            end
                        end else begin
                            idx_n = idx + 4'd1;
                        end
                    end else begin
                        state_n = LOSE;
                    end
                end
`ifdef PLAYER_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_n = LOSE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Display outputs follow the state one cycle later so mostrar can capture the
    // combinational outMem for the address already presented.
    always_ff @(posedge clock) begin
        if (!Resetn) begin
            idx          <= 4'd0;
            ronda        <= 4'd0;
            aciertos     <= 6'd0;
            cnt          <= '0;
            iniciar_prev <= 1'b0;
            enter_prev   <= 1'b0;
            mostrar      <= 4'd0;
            dispOn       <= 1'b0;
            fin          <= 1'b0;
            gano         <= 1'b0;
            perdio       <= 1'b0;
        end else begin
            idx          <= idx_n;
            ronda        <= ronda_n;
            aciertos     <= aciertos_n;
            cnt          <= cnt_n;
            iniciar_prev <= iniciar;
            enter_prev   <= enter;
            dispOn       <= (state == SHOW);
            if (state == SHOW) begin
                mostrar <= outMem;
            end else if (state == INPUT) begin
                mostrar <= guess;
            end else begin
                mostrar <= 4'd0;
            end
            fin    <= (state_n == WIN) || (state_n == LOSE);
            gano   <= (state_n == WIN);
            perdio <= (state_n == LOSE);
        end
    end

endmodule

// File: tb/tb_memory_player.sv
// Directed bench for memory_player: fixed memory 3,7,1,9,2,8,5,4,6 served combinationally.
module tb_memory_player;

    logic       clock = 1'b0;
    logic       Resetn, iniciar, listo, enter;
    logic [3:0] outMem, readAdd, guess, mostrar, ronda;
    logic       dispOn, fin, gano, perdio;
    logic [5:0] aciertos;

    logic [3:0] mem [9] = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd2, 4'd8, 4'd5, 4'd4, 4'd6};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    assign outMem = (readAdd < 4'd9) ? mem[readAdd] : 4'd0;

    memory_player dut (
        .clock   (clock),
        .Resetn  (Resetn),
        .iniciar (iniciar),
        .listo   (listo),
        .outMem  (outMem),
        .readAdd (readAdd),
        .guess   (guess),
        .enter   (enter),
        .mostrar (mostrar),
        .dispOn  (dispOn),
        .ronda   (ronda),
        .aciertos(aciertos),
        .fin     (fin),
        .gano    (gano),
        .perdio  (perdio)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic press(input logic [3:0] g);
        guess = g;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    // INPUT is recognised by mostrar echoing the sentinel guess 15 with the display off
    task automatic wait_input(output bit ok);
        guess = 4'd15;
        ok    = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mostrar === 4'd15 && dispOn === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; iniciar = 1'b0; enter = 1'b0; listo = 1'b1; guess = 4'd0;
        repeat (3) step();
        n_checks++;
        if ({readAdd, mostrar, dispOn, ronda, aciertos, fin, gano, perdio} !== 24'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {readAdd, mostrar, dispOn, ronda, aciertos, fin, gano, perdio});
        else n_pass++;
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_show_gap();
        int run;
        guess = 4'd15;
        pulse_iniciar();
        n_checks++;
        if (ronda !== 4'd1 || dispOn !== 1'b0) $display("FAIL start_ronda: ronda %0d dispOn %0b want 1 0", ronda, dispOn);
        else n_pass++;
        step();
        n_checks++;
        if (dispOn !== 1'b1 || mostrar !== 4'd3 || readAdd !== 4'd0)
            $display("FAIL show_first: dispOn %0b mostrar %0d readAdd %0d want 1 3 0", dispOn, mostrar, readAdd);
        else n_pass++;
        run = 0;
        while (dispOn === 1'b1 && run < 300) begin run++; step(); end
        n_checks++;
        if (run != 100) $display("FAIL show_length: got %0d want 100", run);
        else n_pass++;
        run = 0;
        while (dispOn === 1'b0 && mostrar === 4'd0 && run < 300) begin run++; step(); end
        n_checks++;
        if (run != 25) $display("FAIL gap_length: got %0d want 25", run);
        else n_pass++;
        n_checks++;
        if (mostrar !== 4'd15 || ronda !== 4'd1 || readAdd !== 4'd0)
            $display("FAIL input_round1: mostrar %0d ronda %0d readAdd %0d want 15 1 0", mostrar, ronda, readAdd);
        else n_pass++;
    endtask

    task automatic test_full_win();
        bit ok;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                wait_input(ok);
                n_checks++;
                if (!ok) $display("FAIL win_reach_input: round %0d timeout", k);
                else n_pass++;
            end
            for (int i = 0; i < k; i++) press(mem[i]);
            if (k < 9) begin
                n_checks++;
                if (ronda !== 4'(k + 1) || aciertos !== 6'(k * (k + 1) / 2))
                    $display("FAIL win_round_adv: ronda %0d aciertos %0d want %0d %0d",
                             ronda, aciertos, k + 1, k * (k + 1) / 2);
                else n_pass++;
            end
        end
        n_checks++;
        if ({fin, gano, perdio} !== 3'b110 || aciertos !== 6'd45 || ronda !== 4'd9)
            $display("FAIL win_final: fin/gano/perdio %b aciertos %0d ronda %0d want 110 45 9",
                     {fin, gano, perdio}, aciertos, ronda);
        else n_pass++;
    endtask

    task automatic test_lose();
        bit ok;
        pulse_iniciar();
        n_checks++;
        if ({fin, gano, perdio} !== 3'b000 || ronda !== 4'd1 || aciertos !== 6'd0)
            $display("FAIL restart_from_win: flags %b ronda %0d aciertos %0d want 000 1 0",
                     {fin, gano, perdio}, ronda, aciertos);
        else n_pass++;
        wait_input(ok);
        // iniciar together with enter in INPUT: only the entry counts
        guess = 4'd3; enter = 1'b1; iniciar = 1'b1;
        step();
        enter = 1'b0; iniciar = 1'b0;
        step();
        n_checks++;
        if (ronda !== 4'd2 || aciertos !== 6'd1 || !ok)
            $display("FAIL simultaneous_edges: ronda %0d aciertos %0d want 2 1", ronda, aciertos);
        else n_pass++;
        wait_input(ok);
        press(4'd3); press(4'd7);
        wait_input(ok);
        press(4'd3); press(4'd7);
        n_checks++;
        if (aciertos !== 6'd5 || perdio !== 1'b0 || !ok)
            $display("FAIL lose_partial: aciertos %0d perdio %0b want 5 0", aciertos, perdio);
        else n_pass++;
        press(4'd5);
        n_checks++;
        if ({fin, gano, perdio} !== 3'b101 || aciertos !== 6'd5 || ronda !== 4'd3)
            $display("FAIL lose_final: flags %b aciertos %0d ronda %0d want 101 5 3",
                     {fin, gano, perdio}, aciertos, ronda);
        else n_pass++;
        press(4'd1);
        n_checks++;
        if (aciertos !== 6'd5 || perdio !== 1'b1)
            $display("FAIL enter_in_lose: aciertos %0d perdio %0b want 5 1", aciertos, perdio);
        else n_pass++;
    endtask

    task automatic test_wait_ready();
        bit ok;
        listo = 1'b0;
        pulse_iniciar();
        for (int i = 0; i < 20; i++) begin
            enter = i[0];
            step();
        end
        enter = 1'b0;
        n_checks++;
        if (dispOn !== 1'b0 || ronda !== 4'd1 || aciertos !== 6'd0 || perdio !== 1'b0)
            $display("FAIL wait_rdy_hold: dispOn %0b ronda %0d aciertos %0d perdio %0b want 0 1 0 0",
                     dispOn, ronda, aciertos, perdio);
        else n_pass++;
        listo = 1'b1;
        step();
        n_checks++;
        if (dispOn !== 1'b0) $display("FAIL wait_rdy_exit_early: dispOn %0b want 0", dispOn);
        else n_pass++;
        step();
        n_checks++;
        if (dispOn !== 1'b1 || mostrar !== 4'd3) $display("FAIL wait_rdy_show: dispOn %0b mostrar %0d want 1 3", dispOn, mostrar);
        else n_pass++;
        // listo dropped mid-game and enters during SHOW must both be ignored
        listo = 1'b0;
        guess = 4'd3;
        for (int i = 0; i < 3; i++) begin
            enter = 1'b1; step(); enter = 1'b0; step();
        end
        wait_input(ok);
        n_checks++;
        if (!ok || aciertos !== 6'd0 || ronda !== 4'd1)
            $display("FAIL enter_in_show: aciertos %0d ronda %0d want 0 1", aciertos, ronda);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) wait_input(ok);
            for (int i = 0; i < k; i++) press(mem[i]);
        end
        for (int i = 0; i < 200 && dispOn !== 1'b1; i++) step();
        for (int i = 0; i < 200 && dispOn !== 1'b0; i++) step();
        n_checks++;
        if (ronda !== 4'd4 || aciertos !== 6'd6 || dispOn !== 1'b0)
            $display("FAIL round4_gap: ronda %0d aciertos %0d dispOn %0b want 4 6 0", ronda, aciertos, dispOn);
        else n_pass++;
        Resetn = 1'b0;
        step();
        n_checks++;
        if ({readAdd, mostrar, dispOn, ronda, aciertos, fin, gano, perdio} !== 24'd0)
            $display("FAIL midgame_reset: got %h want 0",
                     {readAdd, mostrar, dispOn, ronda, aciertos, fin, gano, perdio});
        else n_pass++;
        Resetn = 1'b1;
        listo  = 1'b1;
        step();
        pulse_iniciar();
        wait_input(ok);
        n_checks++;
        if (!ok || ronda !== 4'd1 || aciertos !== 6'd0 || readAdd !== 4'd0)
            $display("FAIL restart_after_reset: ronda %0d aciertos %0d readAdd %0d want 1 0 0",
                     ronda, aciertos, readAdd);
        else n_pass++;
    endtask

    task automatic test_bad_digit();
        bit ok;
        press(4'd12);
        n_checks++;
        if ({fin, gano, perdio} !== 3'b101 || aciertos !== 6'd0 || ronda !== 4'd1)
            $display("FAIL guess_above_9: flags %b aciertos %0d ronda %0d want 101 0 1",
                     {fin, gano, perdio}, aciertos, ronda);
        else n_pass++;
        pulse_iniciar();
        wait_input(ok);
        press(4'd0);
        n_checks++;
        if (!ok || perdio !== 1'b1 || aciertos !== 6'd0)
            $display("FAIL guess_zero: perdio %0b aciertos %0d want 1 0", perdio, aciertos);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        pulse_iniciar();
        wait_input(ok);
`ifdef PLAYER_TIMEOUT_EN
        repeat (990) step();
        n_checks++;
        if (!ok || perdio !== 1'b0) $display("FAIL timeout_early: perdio %0b want 0", perdio);
        else n_pass++;
        repeat (20) step();
        n_checks++;
        if ({fin, perdio} !== 2'b11) $display("FAIL timeout_lose: fin/perdio %b want 11", {fin, perdio});
        else n_pass++;
`else
        repeat (5000) step();
        n_checks++;
        if (!ok || perdio !== 1'b0 || fin !== 1'b0 || mostrar !== 4'd15 || dispOn !== 1'b0)
            $display("FAIL no_timeout: perdio %0b fin %0b mostrar %0d want 0 0 15", perdio, fin, mostrar);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_show_gap();
        test_full_win();
        test_lose();
        test_wait_ready();
        test_bad_digit();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
